// File: rtl/result_bcd_display_if.sv
`default_nettype none
// ============================================================================
// Module   : result_bcd_display_if
// Brief    : Load/value capture and seven-segment drive bundle for result_bcd_display.
// Revision : 1.0 - initial release
// ============================================================================
interface result_bcd_display_if;
  logic       load;
  logic [7:0] value;
  logic       busy;
  logic       valid;
  logic [3:0] an;
  logic [6:0] seg;

  modport master (
    output load,
    output value,
    input  busy,
    input  valid,
    input  an,
    input  seg
  );

  modport slave (
    input  load,
    input  value,
    output busy,
    output valid,
    output an,
    output seg
  );
endinterface
`default_nettype wire

// File: rtl/result_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : result_bcd_display
// Brief    : Sequential double-dabble of an 8-bit value onto a multiplexed
//            common-anode 7-segment display. RESULT_BCD_LZB_EN enables
//            leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module result_bcd_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  wire logic clk,
  input  wire logic rst,
  result_bcd_display_if.slave disp
);

  localparam int C_RCW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [C_RCW-1:0] C_REFRESH_LAST = C_RCW'(REFRESH_DIV - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  state_t           r_state;
  logic [7:0]       r_shift;
  logic [11:0]      r_bcd;
  logic [2:0]       r_cnt;
  logic             r_busy;
  logic             r_valid;
  logic [3:0]       r_hund;
  logic [3:0]       r_tens;
  logic [3:0]       r_ones;
  logic [C_RCW-1:0] r_refresh;
  logic [1:0]       r_scan;

  logic [11:0]      w_adj;
  logic [11:0]      w_bcd_nxt;
  logic [3:0]       w_digit;
  logic             w_blank;
  logic [3:0]       w_an;
  logic [6:0]       w_seg;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 3; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_bcd_nxt = {w_adj[10:0], r_shift[7]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shift <= 8'd0;
      r_bcd   <= 12'd0;
      r_cnt   <= 3'd0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_hund  <= 4'd0;
      r_tens  <= 4'd0;
      r_ones  <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (disp.load) begin
            r_shift <= disp.value;
            r_bcd   <= 12'd0;
            r_cnt   <= 3'd0;
            r_busy  <= 1'b1;
            r_state <= ST_CONV;
          end
        end
        ST_CONV: begin
          r_bcd   <= w_bcd_nxt;
          // w_adj[11] is always 0 (hundreds never exceeds 2), so this fills with zero.
          r_shift <= {r_shift[6:0], w_adj[11]};
          r_cnt   <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_hund  <= w_bcd_nxt[11:8];
            r_tens  <= w_bcd_nxt[7:4];
            r_ones  <= w_bcd_nxt[3:0];
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_refresh <= '0;
      r_scan    <= 2'd0;
    end else if (r_refresh == C_REFRESH_LAST) begin
      r_refresh <= '0;
      r_scan    <= (r_scan == 2'd2) ? 2'd0 : r_scan + 2'd1;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  always_comb begin
    w_an  = 4'b1111;
    w_seg = 7'b1111111;
    case (r_scan)
      2'd1:    w_digit = r_tens;
      2'd2:    w_digit = r_hund;
      default: w_digit = r_ones;
    endcase
`ifdef RESULT_BCD_LZB_EN
    w_blank = ((r_scan == 2'd2) && (r_hund == 4'd0)) ||
              ((r_scan == 2'd1) && (r_hund == 4'd0) && (r_tens == 4'd0));
`else
    w_blank = 1'b0;
`endif
    if (r_valid && !w_blank) begin
      w_an[r_scan] = 1'b0;
      w_seg        = seg_encode(w_digit);
    end
  end

  assign disp.busy  = r_busy;
  assign disp.valid = r_valid;
  assign disp.an    = w_an;
  assign disp.seg   = w_seg;

endmodule
`default_nettype wire

// File: tb/tb_result_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_bcd_display
// Brief    : Directed self-checking bench for result_bcd_display (REFRESH_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_bcd_display;
  localparam int RDIV = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   k = 0;
  logic       exp_valid = 1'b0;
  logic [3:0] eh = 4'd0;
  logic [3:0] et = 4'd0;
  logic [3:0] eo = 4'd0;

  result_bcd_display_if dif ();

  result_bcd_display #(.REFRESH_DIV(RDIV)) dut (
    .clk  (clk),
    .rst  (rst),
    .disp (dif)
  );

  always #5 clk = ~clk;

  // Non-reset edges since the last reset; scan slot = (k / RDIV) % 3.
  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  task automatic chk_disp();
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic [3:0] d;
    logic       blank;
    int         s;
    s     = (k / RDIV) % 3;
    an_e  = 4'b1111;
    seg_e = 7'b1111111;
    d     = (s == 0) ? eo : (s == 1) ? et : eh;
    blank = 1'b0;
`ifdef RESULT_BCD_LZB_EN
    blank = ((s == 2) && (eh == 4'd0)) || ((s == 1) && (eh == 4'd0) && (et == 4'd0));
`endif
    if (exp_valid && !blank) begin
      an_e[s] = 1'b0;
      seg_e   = enc(d);
    end
    chk("an", dif.an, an_e);
    chk("seg", dif.seg, seg_e);
  endtask

  task automatic conv(input logic [7:0] v, input logic [3:0] h, input logic [3:0] t,
                      input logic [3:0] o, input int nscan);
    dif.value = v;
    dif.load  = 1'b1;
    step();
    dif.load  = 1'b0;
    dif.value = ~v;
    for (int i = 0; i < 8; i++) begin
      chk("busy_conv", dif.busy, 1'b1);
      chk("valid_conv", dif.valid, exp_valid);
      chk_disp();
      step();
    end
    eh = h; et = t; eo = o; exp_valid = 1'b1;
    chk("busy_done", dif.busy, 1'b0);
    chk("valid_done", dif.valid, 1'b1);
    for (int i = 0; i < nscan; i++) begin
      chk_disp();
      step();
    end
  endtask

  initial begin
    rst       = 1'b1;
    dif.load  = 1'b0;
    dif.value = 8'd0;
    step();
    step();
    chk("rst_busy", dif.busy, 1'b0);
    chk("rst_valid", dif.valid, 1'b0);
    chk("rst_an", dif.an, 4'b1111);
    chk("rst_seg", dif.seg, 7'b1111111);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      chk_disp();
      step();
    end

    conv(8'd8,   4'd0, 4'd0, 4'd8, 12);
    conv(8'd15,  4'd0, 4'd1, 4'd5, 0);
    conv(8'd255, 4'd2, 4'd5, 4'd5, 12);
    conv(8'd0,   4'd0, 4'd0, 4'd0, 12);
    conv(8'd105, 4'd1, 4'd0, 4'd5, 12);

    // Second load three cycles into a conversion must be ignored.
    dif.value = 8'd15;
    dif.load  = 1'b1;
    step();
    dif.load  = 1'b0;
    step();
    step();
    dif.value = 8'd99;
    dif.load  = 1'b1;
    step();
    dif.load  = 1'b0;
    for (int i = 3; i < 8; i++) begin
      chk("busy_ign", dif.busy, 1'b1);
      step();
    end
    eh = 4'd0; et = 4'd1; eo = 4'd5;
    chk("busy_ign_done", dif.busy, 1'b0);
    chk("valid_ign_done", dif.valid, 1'b1);
    step();
    chk("busy_no_requeue", dif.busy, 1'b0);
    for (int i = 0; i < 12; i++) begin
      chk_disp();
      step();
    end

    // Reset four cycles into a conversion discards everything.
    dif.value = 8'd200;
    dif.load  = 1'b1;
    step();
    dif.load  = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    chk("midrst_busy", dif.busy, 1'b0);
    chk("midrst_valid", dif.valid, 1'b0);
    chk("midrst_an", dif.an, 4'b1111);
    chk("midrst_seg", dif.seg, 7'b1111111);
    exp_valid = 1'b0;
    eh = 4'd0; et = 4'd0; eo = 4'd0;
    rst = 1'b0;
    chk_disp();
    conv(8'd42, 4'd0, 4'd4, 4'd2, 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
